uart_rx_line_fifo: RTL and testbench
====================================

Name: uart_rx_line_fifo

Overview:
Byte FIFO directly downstream of the UART receiver, on the same clock. Captures each received byte on the rising edge of the receiver's byte-ready level and buffers it for a consumer over a first-word-fall-through valid/ready interface. Tracks how many complete end-of-line-terminated lines are buffered, so a command parser can wait for a whole line before draining. Reports overflow with a sticky flag.

Parameters:
DEPTH, 16, number of byte entries; power of two, at least 2; local ADDR_W = clog2(DEPTH)
EOL_CHAR, 8'h0D, byte value that terminates a line

Ports:
clk  input  1  system clock (66 MHz PLL domain)
rst_n  input  1  asynchronous active-low reset
in_data  input  8  received byte from UART receiver, stable while in_strobe high
in_strobe  input  1  receiver byte-ready level; a write is triggered by its rising edge only
out_data  output  8  head byte; 8'h00 when out_valid=0
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head byte
count  output  ADDR_W+1  bytes currently stored, 0..DEPTH
line_count  output  ADDR_W+1  stored bytes equal to EOL_CHAR
line_avail  output  1  line_count != 0
overflow  output  1  sticky: a byte was dropped because the FIFO was full
clear_ovf  input  1  synchronous clear of overflow
flush  input  1  synchronous discard of all contents

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, line_count=0, strobe_q=0, overflow=0; hence out_valid=0, out_data=8'h00, line_avail=0. Storage array is not reset.
- Edge detect: push_req = in_strobe & ~strobe_q; strobe_q <= in_strobe every cycle. A level held high for many cycles yields exactly one write. in_strobe high at reset release counts as one edge.
- pop = out_valid & out_ready.
- push = push_req & (count<DEPTH | pop). A push when full is accepted only with a simultaneous pop.
- Latency: push in cycle N -> byte stored at end of N -> out_valid/count updated in N+1. Empty plus push: no pop that cycle; byte visible in N+1.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count = count + push - pop.
- line_count: +1 when a pushed byte equals EOL_CHAR; -1 when the popped head equals EOL_CHAR; both in the same cycle -> unchanged.
- Overflow: push_req while full without pop -> byte dropped, not counted in line_count, overflow<=1. clear_ovf clears it; a simultaneous set wins.
- Flush: pointers, count and line_count go to 0 next cycle. flush has priority over push and pop in the same cycle (that byte is lost; overflow is not set). overflow is unaffected; strobe_q still updates.
- out_data = mem[rd_ptr] combinationally when out_valid, else 8'h00. It is stable while out_valid=1 and out_ready=0.
- Reset mid-stream: all contents and flags are discarded immediately; no partial state survives.
- No other FSM. Control consists of the edge detector plus counters; all outputs derive from registers.

Decomposition:
- Shared package uart_pkg: byte typedef (8-bit), EOL_CR=8'h0D, EOL_LF=8'h0A, DELAY_FRAMES default shared with rx/tx.
- One sub-module, uart_fifo_ram: DEPTH x 8 array, registered write port, asynchronous read port. Pointer, count, line and flag logic stays in the top.

Test Plan:
- Reset, then hold in_strobe high 10 cycles with in_data=8'h41 -> exactly one entry; count=1, out_valid=1, out_data=8'h41 one cycle after the edge.
- Push "AB\r" with out_ready=0 -> count=3, line_count=1, line_avail=1. Pop 3 -> bytes 41,42,0D in order; line_count=0 after the 0D pop; out_data=00.
- Push 17 bytes (0x00..0x10) with DEPTH=16 and no reads -> count=16, overflow=1, byte 0x10 absent. Drain reads 0x00..0x0F. clear_ovf -> overflow=0.
- Full FIFO, push edge and out_ready=1 in the same cycle -> count stays 16, overflow stays 0, new byte is read last. Then clear_ovf together with another overflow push -> overflow=1.
- Push 0D with a simultaneous pop of head 0D -> line_count unchanged. Push past a pointer wrap (20 push/pop pairs) -> data order preserved, count correct.
- Mid-stream with 5 bytes stored, assert flush with a push edge -> next cycle count=0, line_count=0, out_valid=0, overflow unchanged. Assert rst_n=0 asynchronously between clock edges -> outputs clear immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, line terminators
// and the frame-delay default used by rx/tx blocks.
package uart_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t EOL_CR       = 8'h0D;
    localparam byte_t EOL_LF       = 8'h0A;
    localparam int    DELAY_FRAMES = 2;

    function automatic logic is_eol(input byte_t b, input byte_t eol);
        return b == eol;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 storage for the rx line FIFO.
// Ports: clk, i_we/i_waddr/i_wdata (registered write), i_raddr/o_rdata (async read).
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  byte_t             i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output byte_t             o_rdata
);

    byte_t r_mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_line_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, counting
// buffered EOL-terminated lines and flagging dropped bytes (sticky).
// Ports: clk, rst_n, in_data/in_strobe (byte-ready level, rising edge writes),
// out_data/out_valid/out_ready, count, line_count, line_avail, overflow,
// clear_ovf, flush.
module uart_rx_line_fifo
    import uart_pkg::*;
#(
    parameter  int    DEPTH    = 16,
    parameter  byte_t EOL_CHAR = EOL_CR,
    localparam int    ADDR_W   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  byte_t           in_data,
    input  logic            in_strobe,
    output byte_t           out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ADDR_W:0] count,
    output logic [ADDR_W:0] line_count,
    output logic            line_avail,
    output logic            overflow,
    input  logic            clear_ovf,
    input  logic            flush
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_line_count;
    logic              r_strobe_q;
    logic              r_overflow;

    byte_t w_rd_data;
    logic  w_push_req;
    logic  w_full;
    logic  w_pop;
    logic  w_push;
    logic  w_wr_en;
    logic  w_ovf_set;
    logic  w_push_eol;
    logic  w_pop_eol;

    assign w_push_req = in_strobe & ~r_strobe_q;
    assign w_full     = (r_count == FULL_CNT);
    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid & out_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_wr_en    = w_push & ~flush;
    assign w_ovf_set  = w_push_req & w_full & ~w_pop & ~flush;
    assign w_push_eol = w_push & is_eol(in_data, EOL_CHAR);
    assign w_pop_eol  = w_pop & is_eol(w_rd_data, EOL_CHAR);

    assign out_data   = out_valid ? w_rd_data : 8'h00;
    assign count      = r_count;
    assign line_count = r_line_count;
    assign line_avail = (r_line_count != '0);
    assign overflow   = r_overflow;

    uart_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe_q <= 1'b0;
        end else begin
            r_strobe_q <= in_strobe;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_line_count <= '0;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_line_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            unique case ({w_push_eol, w_pop_eol})
                2'b10:   r_line_count <= r_line_count + CNT_W'(1);
                2'b01:   r_line_count <= r_line_count - CNT_W'(1);
                default: r_line_count <= r_line_count;
            endcase
        end
    end

    // Set beats clear when both happen in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_line_fifo.sv
// Self-checking bench for uart_rx_line_fifo: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_uart_rx_line_fifo;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [7:0]  EOL   = 8'h0D;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_strobe;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   count;
    logic [AW:0]   line_count;
    logic          line_avail;
    logic          overflow;
    logic          clear_ovf;
    logic          flush;

    uart_rx_line_fifo #(
        .DEPTH    (DEPTH),
        .EOL_CHAR (EOL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_strobe  (in_strobe),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .line_count (line_count),
        .line_avail (line_avail),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_prev;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eol_cnt();
        int n = 0;
        foreach (mq[i]) if (mq[i] == EOL) n++;
        return n;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_prev = 1'b0;
    endtask

    task automatic model_step();
        bit edge_, popm, full;
        edge_  = in_strobe && !m_prev;
        m_prev = in_strobe;
        popm   = (mq.size() > 0) && out_ready;
        full   = (mq.size() == DEPTH);
        if (flush) begin
            mq.delete();
            if (clear_ovf) m_ovf = 1'b0;
        end else begin
            if (edge_ && full && !popm) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
            if (popm) void'(mq.pop_front());
            if (edge_ && (!full || popm)) mq.push_back(in_data);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] hd;
        int lc;
        hd = (mq.size() != 0) ? mq[0] : 8'h00;
        lc = eol_cnt();
        chk({tag, ".valid"}, out_valid, mq.size() != 0);
        chk({tag, ".data"}, out_data, hd);
        chk({tag, ".count"}, count, mq.size());
        chk({tag, ".lines"}, line_count, lc);
        chk({tag, ".avail"}, line_avail, lc != 0);
        chk({tag, ".ovf"}, overflow, m_ovf);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_data   = b;
        in_strobe = 1'b1;
        step("push");
        in_strobe = 1'b0;
        step("push_lo");
    endtask

    initial begin
        logic [7:0] exp_ab [3];
        exp_ab[0] = 8'h41;
        exp_ab[1] = 8'h42;
        exp_ab[2] = 8'h0D;

        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_strobe = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        flush     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Long strobe level gives one write
        in_data   = 8'h41;
        in_strobe = 1'b1;
        step("hold");
        chk("hold_cnt1", count, 1);
        chk("hold_data", out_data, 8'h41);
        repeat (9) step("hold");
        chk("hold_cnt", count, 1);
        in_strobe = 1'b0;
        out_ready = 1'b1;
        step("hold_pop");
        out_ready = 1'b0;
        chk("hold_empty", count, 0);

        // "AB\r" line
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h0D);
        chk("ab_cnt", count, 3);
        chk("ab_lines", line_count, 1);
        chk("ab_avail", line_avail, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ab_pop", out_data, exp_ab[i]);
            step("ab_pop");
        end
        out_ready = 1'b0;
        chk("ab_lines0", line_count, 0);
        chk("ab_data0", out_data, 8'h00);

        // Overflow with 17 pushes
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        chk("ovf_cnt", count, DEPTH);
        chk("ovf_flag", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain", out_data, i);
            step("drain");
        end
        out_ready = 1'b0;
        clear_ovf = 1'b1;
        step("clr");
        clear_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
        in_data   = 8'h77;
        in_strobe = 1'b1;
        out_ready = 1'b1;
        step("fullpp");
        in_strobe = 1'b0;
        out_ready = 1'b0;
        chk("fullpp_cnt", count, DEPTH);
        chk("fullpp_ovf", overflow, 0);
        step("fullpp_lo");
        in_data   = 8'h88;
        in_strobe = 1'b1;
        clear_ovf = 1'b1;
        step("setclr");
        in_strobe = 1'b0;
        clear_ovf = 1'b0;
        chk("setclr_ovf", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("fulldrain", out_data, (i == 15) ? 8'h77 : 8'(8'h21 + i));
            step("fulldrain");
        end
        out_ready = 1'b0;
        clear_ovf = 1'b1;
        step("clr2");
        clear_ovf = 1'b0;

        // EOL push and EOL pop in the same cycle
        push_byte(8'h0D);
        chk("eol_l1", line_count, 1);
        in_data   = 8'h0D;
        in_strobe = 1'b1;
        out_ready = 1'b1;
        step("eolpp");
        chk("eolpp_lines", line_count, 1);
        chk("eolpp_cnt", count, 1);
        in_strobe = 1'b0;
        step("eolpp_lo");
        out_ready = 1'b0;
        chk("eolpp_l0", line_count, 0);

        // Pointer wrap with push/pop pairs
        for (int i = 0; i < 20; i++) begin
            in_data   = 8'(8'h50 + i);
            in_strobe = 1'b1;
            out_ready = 1'b1;
            step("wrap_push");
            chk("wrap_head", out_data, 8'(8'h50 + i));
            in_strobe = 1'b0;
            step("wrap_pop");
        end
        out_ready = 1'b0;
        chk("wrap_cnt", count, 0);

        // Flush with a push edge, overflow set beforehand
        for (int i = 0; i < 17; i++) push_byte((i == 2) ? 8'h0D : 8'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) step("pre_flush");
        out_ready = 1'b0;
        chk("pre_flush_cnt", count, 5);
        in_data   = 8'h99;
        in_strobe = 1'b1;
        flush     = 1'b1;
        step("flush");
        flush     = 1'b0;
        in_strobe = 1'b0;
        chk("flush_cnt", count, 0);
        chk("flush_lines", line_count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ovf", overflow, 1);
        step("flush_lo");

        // Asynchronous reset mid-stream
        push_byte(8'h0D);
        push_byte(8'h31);
        in_data   = 8'h5A;
        in_strobe = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 8'h00);
        chk("arst_lines", line_count, 0);
        chk("arst_ovf", overflow, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("rel_edge");
        chk("rel_cnt", count, 1);
        chk("rel_data", out_data, 8'h5A);
        in_strobe = 1'b0;
        step("rel_lo");

        // Randomized traffic in phases of varying read pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 700; i++) begin
                in_strobe = 1'($urandom_range(0, 1));
                in_data   = ($urandom_range(0, 3) == 0) ? EOL : 8'($urandom);
                out_ready = ($urandom_range(0, 3) < ph);
                flush     = ($urandom_range(0, 199) == 0);
                clear_ovf = ($urandom_range(0, 49) == 0);
                step("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
